// File: rtl/data_types_pkg.sv
// ---------------------------------------------------------------------------
// data_types_pkg
// Shared constants and types for the rows_writer block.
//   DEF_N_ROWS / DEF_WIDTH / DEF_ADDR_W : default transfer geometry
//   state_e                             : transfer FSM states
//   cnt_width()                         : row counter width, never below 1 bit
// ---------------------------------------------------------------------------
package data_types_pkg;

  localparam int DEF_N_ROWS = 4;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A single-row transfer still needs a 1-bit counter so the
  // datapath keeps a legal, non-zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rows_writer.sv
// ---------------------------------------------------------------------------
// rows_writer
// Captures a bundle of N_ROWS rows plus a base address, then writes the rows
// one by one into an external RAM write port at base_addr + row index
// (wrapping modulo 2^ADDR_W).
// A single-cycle finish_write pulse follows the write of the last row.
//
// Ports
//   clk              : clock; all logic is rising-edge
//   rst              : synchronous, active-high reset
//   in_valid         : a row bundle and base address are offered
//   in_ready         : the block can accept a bundle (IDLE only)
//   in_rows          : N_ROWS x WIDTH bundle; row 0 is in the LSBs
//   base_addr        : RAM address for row 0
//   ram_grant        : the RAM accepts a write this cycle
//   ram_addr         : RAM write address
//   ram_data_in      : RAM write data
//   ram_write_enable : RAM write strobe
//   finish_write     : one-cycle pulse after the last row is written
// ---------------------------------------------------------------------------
module rows_writer
  import data_types_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_ROWS*WIDTH-1:0]   in_rows,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      ram_grant,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [WIDTH-1:0]          ram_data_in,
  output logic                      ram_write_enable,
  output logic                      finish_write
);

  localparam int              CNT_W    = cnt_width(N_ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N_ROWS - 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               row_cnt_q, row_cnt_d;
  logic [N_ROWS-1:0][WIDTH-1:0]   rows_q, rows_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic                           write_en_raw;

  // State, counter and capture registers. Clearing the captured bundle and
  // base on reset is what makes ram_addr / ram_data_in read back as zero
  // straight after reset, since both are derived from these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      rows_q    <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      rows_q    <= rows_d;
      base_q    <= base_d;
    end
  end

  // Next-state and output decode. The counter stops at the last row instead
  // of rolling past it, so it never exceeds N_ROWS-1 and the data mux index
  // always stays inside the captured bundle.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    rows_d       = rows_q;
    base_d       = base_q;
    in_ready     = 1'b0;
    write_en_raw = 1'b0;
    finish_write = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rows_d    = in_rows;
          base_d    = base_addr;
          row_cnt_d = '0;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        write_en_raw = 1'b1;
        if (ram_grant) begin
          if (row_cnt_q == LAST_ROW) begin
            state_d = DONE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        finish_write = 1'b1;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The strobe is masked while reset is asserted so that a transfer aborted
  // by reset cannot land one more row in the RAM during the reset cycle.
  assign ram_write_enable = write_en_raw & ~rst;
  assign ram_addr         = base_q + ADDR_W'(row_cnt_q);
  assign ram_data_in      = rows_q[row_cnt_q];

endmodule

// File: doc/rows_writer.md
ROWS_WRITER -- requirements
Module: rows_writer

Interface
REQ-001 The block SHALL take parameter N_ROWS, default 4, the number of rows per transfer.
REQ-002 The block SHALL take parameter WIDTH, default 32, the bits per row.
REQ-003 The block SHALL take parameter ADDR_W, default 4, the RAM address width.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  a row bundle and base address are offered.
REQ-007 in_ready  output  1  the block can accept a bundle.
REQ-008 in_rows  input  N_ROWS x WIDTH  row bundle; row 0 occupies the least significant WIDTH bits.
REQ-009 base_addr  input  ADDR_W  RAM address for row 0.
REQ-010 ram_grant  input  1  the RAM accepts a write this cycle.
REQ-011 ram_addr  output  ADDR_W  RAM write address.
REQ-012 ram_data_in  output  WIDTH  RAM write data.
REQ-013 ram_write_enable  output  1  write strobe.
REQ-014 finish_write  output  1  one-cycle pulse after the last row is written.

Function
REQ-015 The FSM SHALL have three states: IDLE, WRITE, DONE.
REQ-016 In IDLE, in_ready SHALL be 1 and ram_write_enable SHALL be 0.
REQ-017 On in_valid && in_ready, the block SHALL capture in_rows and base_addr into internal registers, clear row_cnt and go to WRITE on the same edge.
REQ-018 In WRITE, ram_write_enable SHALL be 1, ram_addr SHALL equal captured base_addr + row_cnt (mod 2^ADDR_W), and ram_data_in SHALL equal captured row[row_cnt].
REQ-019 A row SHALL count as written only in a cycle where ram_write_enable && ram_grant; row_cnt SHALL then increment.
REQ-020 With ram_grant low, row_cnt, ram_addr and ram_data_in SHALL hold their values.
REQ-021 When row N_ROWS-1 is written, the FSM SHALL go to DONE.
REQ-022 In DONE, the block SHALL assert finish_write for exactly one cycle, keep ram_write_enable at 0, and return to IDLE.
REQ-023 in_ready SHALL be 0 in WRITE and DONE; in_valid in those states SHALL be ignored, and the captured data SHALL be unaffected by in_rows/base_addr changes.
REQ-024 Latency: with acceptance at edge T and ram_grant held at 1, row k SHALL be written in cycle T+1+k, finish_write SHALL be high in cycle T+1+N_ROWS, and in_ready SHALL be high again in cycle T+2+N_ROWS.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W; no error indication is raised on wrap.
REQ-026 row_cnt SHALL be ceil(log2(N_ROWS)) bits wide, minimum 1, and SHALL never exceed N_ROWS-1.
REQ-027 The design SHALL support N_ROWS=1, in which case the transfer takes a single WRITE cycle when granted.

Reset
REQ-028 When rst is sampled high, the state SHALL become IDLE, row_cnt 0, ram_write_enable 0, finish_write 0, ram_addr 0, ram_data_in 0, in_ready 1 from the next cycle.
REQ-029 rst SHALL take priority over all other inputs, including in_valid in the same cycle.
REQ-030 A reset during WRITE SHALL abort the transfer with no further writes and no finish_write pulse.

Structure
REQ-031 N_ROWS and WIDTH default constants and the state enum typedef (IDLE/WRITE/DONE) SHALL live in data_types_pkg.
REQ-032 The RAM SHALL stay outside the block; the block drives its write port only.
REQ-033 No sub-module is required; the capture register, counter and FSM SHALL be in one module.

Verification
REQ-034 Basic: base_addr=3, rows {0x44,0x33,0x22,0x11}, grant=1 -> writes (3,0x11),(4,0x22),(5,0x33),(6,0x44) in consecutive cycles; finish_write in the following cycle.
REQ-035 Wrap: base_addr=14, ADDR_W=4 -> addresses 14, 15, 0, 1.
REQ-036 Stall: drop grant for 3 cycles after row 1 -> addr/data hold at row 2, total WRITE time 7 cycles, data order intact.
REQ-037 Busy: in_valid high with new data during WRITE -> in_ready=0, the original data is written, and the new bundle is accepted only in IDLE.
REQ-038 Reset: assert rst after row 1 is written -> no further ram_write_enable, no finish_write, in_ready=1 next cycle, and a fresh transfer works.
REQ-039 Back-to-back: in_valid held high -> a second bundle is accepted in the first IDLE cycle after DONE (gap of exactly 1 idle cycle).
